// File: rtl/video_render_pkg.sv
// rtl/video_render_pkg.sv - shared constants and helpers for the pixel renderer
package video_render_pkg;

  localparam logic [1:0] MODE_ZX    = 2'd0;
  localparam logic [1:0] MODE_P16   = 2'd1;
  localparam logic [1:0] MODE_HIRES = 2'd2;

  localparam int GRP_LEN_7  = 16;
  localparam int GRP_LEN_14 = 32;

  localparam int ATTR_INK_LSB   = 0;
  localparam int ATTR_PAPER_LSB = 3;
  localparam int ATTR_BRIGHT    = 6;
  localparam int ATTR_FLASH     = 7;

  // The reserved encoding renders as ZX.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_ZX : m;
  endfunction

endpackage

// File: rtl/video_render_zx_attr_decode.sv
// rtl/video_render_zx_attr_decode.sv - ZX-style attribute decode shared by ZX and HIRES
module zx_attr_decode
  import video_render_pkg::*;
(
  input  logic [7:0] attr,
  input  logic       pix_bit,
  input  logic       flash,
  output logic [3:0] colour
);

  logic [2:0] ink;
  logic [2:0] paper;
  logic       swap;
  logic       use_ink;

  always_comb begin
    ink     = attr[ATTR_INK_LSB +: 3];
    paper   = attr[ATTR_PAPER_LSB +: 3];
    swap    = attr[ATTR_FLASH] & flash;
    use_ink = pix_bit ^ swap;
    colour  = {attr[ATTR_BRIGHT], use_ink ? ink : paper};
  end

endmodule

// File: rtl/video_render.sv
// rtl/video_render.sv - serialises fetched 64-bit groups into per-pixel palette indices
module video_render
  import video_render_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_sync,
  input  logic [63:0] pic_bits,
  input  logic        stb7,
  input  logic        stb14,
  input  logic [1:0]  mode,
  input  logic        flash,
  input  logic        pix_win,
  input  logic [3:0]  border,
  output logic [3:0]  colour,
  output logic        underrun
);

  logic        fetch_sync_d;
  logic        ld_pend;
  logic        grp_done;
  logic        loaded_once;
  logic [1:0]  cur_mode;
  logic [4:0]  pix_cnt;
  logic [63:0] pix_buf;

  logic [1:0]  new_mode;
  logic        strb_new;
  logic        strb_cur;
  logic        load;
  logic        advance;
  logic        starve;
  logic [4:0]  last_idx;

  logic [63:0] sel_buf;
  logic [1:0]  sel_mode;
  logic [4:0]  sel_p;
  logic [2:0]  bm_idx;
  logic [2:0]  at_idx;
  logic [7:0]  bm_byte;
  logic [7:0]  at_byte;
  logic [7:0]  p16_byte;
  logic [3:0]  p16_nib;
  logic        pix_bit;
  logic [3:0]  zx_colour;
  logic [3:0]  next_pix;

  // The loading strobe follows the incoming mode; strobes within a group follow the captured one.
  always_comb begin
    new_mode = norm_mode(mode);
    strb_new = (new_mode == MODE_HIRES) ? stb14 : stb7;
    strb_cur = (cur_mode == MODE_HIRES) ? stb14 : stb7;
    load     = strb_new & (ld_pend | fetch_sync_d);
    last_idx = (cur_mode == MODE_HIRES) ? 5'(GRP_LEN_14 - 1) : 5'(GRP_LEN_7 - 1);
    advance  = strb_cur & ~load & ~grp_done & (pix_cnt != last_idx);
    starve   = strb_cur & ~load & ~advance;
  end

  always_comb begin
    sel_buf  = load ? pic_bits : pix_buf;
    sel_mode = load ? new_mode : cur_mode;
    sel_p    = load ? 5'd0 : pix_cnt + 5'd1;
    if (sel_mode == MODE_HIRES) begin
      bm_idx = {1'b0, sel_p[4:3]};
      at_idx = {1'b1, sel_p[4:3]};
    end else begin
      bm_idx = {2'b00, sel_p[3]};
      at_idx = {2'b01, sel_p[3]};
    end
    bm_byte  = sel_buf[{bm_idx, 3'b000} +: 8];
    at_byte  = sel_buf[{at_idx, 3'b000} +: 8];
    pix_bit  = bm_byte[~sel_p[2:0]];
    p16_byte = sel_buf[{sel_p[3:1], 3'b000} +: 8];
    p16_nib  = sel_p[0] ? p16_byte[3:0] : p16_byte[7:4];
    next_pix = (sel_mode == MODE_P16) ? p16_nib : zx_colour;
  end

  zx_attr_decode u_attr (
    .attr    (at_byte),
    .pix_bit (pix_bit),
    .flash   (flash),
    .colour  (zx_colour)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_sync_d <= 1'b0;
      ld_pend      <= 1'b0;
      grp_done     <= 1'b1;
      loaded_once  <= 1'b0;
      cur_mode     <= MODE_ZX;
      pix_cnt      <= 5'd0;
      pix_buf      <= 64'd0;
      colour       <= 4'd0;
      underrun     <= 1'b0;
    end else begin
      fetch_sync_d <= fetch_sync;
      underrun     <= 1'b0;
      // A fresh fetch always re-arms the load, so newer data replaces any unconsumed group.
      if (fetch_sync)
        ld_pend <= 1'b1;
      else if (load)
        ld_pend <= 1'b0;

      if (load) begin
        pix_buf     <= pic_bits;
        cur_mode    <= new_mode;
        pix_cnt     <= 5'd0;
        grp_done    <= 1'b0;
        loaded_once <= 1'b1;
        colour      <= pix_win ? next_pix : border;
      end else if (advance) begin
        pix_cnt <= pix_cnt + 5'd1;
        colour  <= pix_win ? next_pix : border;
      end else if (starve) begin
        grp_done <= 1'b1;
        colour   <= pix_win ? 4'd0 : border;
        underrun <= loaded_once;
      end
    end
  end

endmodule

// File: tb/tb_video_render.sv
// tb/tb_video_render.sv - directed self-checking bench for video_render
module tb_video_render;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_sync = 1'b0;
  logic [63:0] pic_bits = 64'd0;
  logic        stb7 = 1'b0;
  logic        stb14 = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        flash = 1'b0;
  logic        pix_win = 1'b1;
  logic [3:0]  border = 4'd0;
  logic [3:0]  colour;
  logic        underrun;

  int tests = 0;
  int fails = 0;

  localparam logic [63:0] ZX_DATA  = 64'h0000_0000_3847_0FF0;
  localparam logic [63:0] ZX_EXP   = 64'hFFFF_8888_7777_0000;
  localparam logic [63:0] FL_DATA  = 64'h0000_0000_00C1_00FF;
  localparam logic [63:0] P16_DATA = 64'hEFCD_AB89_6745_2301;
  localparam logic [63:0] HI_DATA  = 64'h0A0A_0A0A_AAAA_AAAA;
  localparam logic [63:0] ALT_DATA = 64'h0000_0000_0005_00FF;

  logic [63:0] zx_exp;

  video_render dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_sync (fetch_sync),
    .pic_bits   (pic_bits),
    .stb7       (stb7),
    .stb14      (stb14),
    .mode       (mode),
    .flash      (flash),
    .pix_win    (pix_win),
    .border     (border),
    .colour     (colour),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_fetch(input logic [63:0] bits);
    fetch_sync = 1'b1;
    tick();
    fetch_sync = 1'b0;
    pic_bits   = bits;
  endtask

  task automatic strobe7();
    stb7  = 1'b1;
    stb14 = 1'b1;
    tick();
    stb7  = 1'b0;
    stb14 = 1'b0;
  endtask

  task automatic strobe14();
    stb14 = 1'b1;
    tick();
    stb14 = 1'b0;
  endtask

  initial begin
    zx_exp = ZX_EXP;
    tick();
    tick();
    chk("reset_colour", {4'd0, colour}, 8'h00);
    chk("reset_underrun", {7'd0, underrun}, 8'h00);
    rst = 1'b0;
    tick();

    // Strobe before any load: underrun masked
    strobe7();
    chk("preload_colour", {4'd0, colour}, 8'h00);
    chk("preload_underrun", {7'd0, underrun}, 8'h00);

    // ZX group
    do_fetch(ZX_DATA);
    for (int i = 0; i < 16; i++) begin
      strobe7();
      chk($sformatf("zx_pix%0d", i), {4'd0, colour}, {4'd0, zx_exp[63-4*i -: 4]});
      chk($sformatf("zx_nounder%0d", i), {7'd0, underrun}, 8'h00);
    end

    // ZX flash, swapped then normal
    flash = 1'b1;
    do_fetch(FL_DATA);
    for (int i = 0; i < 8; i++) begin
      strobe7();
      chk($sformatf("flash_on%0d", i), {4'd0, colour}, 8'h08);
    end
    flash = 1'b0;
    do_fetch(FL_DATA);
    for (int i = 0; i < 8; i++) begin
      strobe7();
      chk($sformatf("flash_off%0d", i), {4'd0, colour}, 8'h09);
    end

    // P16 group then underrun
    mode = 2'd1;
    do_fetch(P16_DATA);
    for (int i = 0; i < 16; i++) begin
      strobe7();
      chk($sformatf("p16_pix%0d", i), {4'd0, colour}, 8'(i));
    end
    strobe7();
    chk("p16_under_colour", {4'd0, colour}, 8'h00);
    chk("p16_under_pulse", {7'd0, underrun}, 8'h01);
    tick();
    chk("p16_under_clear", {7'd0, underrun}, 8'h00);

    // HIRES group then underrun
    mode = 2'd2;
    do_fetch(HI_DATA);
    for (int i = 0; i < 32; i++) begin
      strobe14();
      chk($sformatf("hi_pix%0d", i), {4'd0, colour}, (i % 2 == 0) ? 8'h02 : 8'h01);
    end
    strobe14();
    chk("hi_under_colour", {4'd0, colour}, 8'h00);
    chk("hi_under_pulse", {7'd0, underrun}, 8'h01);
    tick();
    chk("hi_under_clear", {7'd0, underrun}, 8'h00);
    chk("hi_colour_hold", {4'd0, colour}, 8'h00);

    // Border on pixels 3..5
    mode   = 2'd0;
    border = 4'h5;
    do_fetch(ZX_DATA);
    for (int i = 0; i < 8; i++) begin
      pix_win = !(i >= 3 && i <= 5);
      strobe7();
      chk($sformatf("bord_pix%0d", i), {4'd0, colour},
          (i >= 3 && i <= 5) ? 8'h05 : {4'd0, zx_exp[63-4*i -: 4]});
    end
    pix_win = 1'b1;

    // Strobe coincident with fetch_sync advances the old group
    fetch_sync = 1'b1;
    stb7 = 1'b1;
    stb14 = 1'b1;
    tick();
    chk("coincident_noload", {4'd0, colour}, 8'h07);
    fetch_sync = 1'b0;
    pic_bits   = ALT_DATA;
    tick();
    chk("delayed_load", {4'd0, colour}, 8'h05);
    stb7 = 1'b0;
    stb14 = 1'b0;

    // Mode change mid-group is deferred to the next load
    mode = 2'd1;
    strobe7();
    chk("midgroup_mode", {4'd0, colour}, 8'h05);
    do_fetch(P16_DATA);
    strobe7();
    chk("newmode_pix0", {4'd0, colour}, 8'h00);
    strobe7();
    chk("newmode_pix1", {4'd0, colour}, 8'h01);

    // Reset at pixel 7
    mode = 2'd0;
    do_fetch(ZX_DATA);
    for (int i = 0; i < 7; i++) strobe7();
    chk("pre_rst_pix6", {4'd0, colour}, 8'h08);
    #1;
    rst = 1'b1;
    #2;
    chk("async_rst_colour", {4'd0, colour}, 8'h00);
    chk("async_rst_underrun", {7'd0, underrun}, 8'h00);
    tick();
    rst = 1'b0;
    strobe7();
    chk("post_rst_colour", {4'd0, colour}, 8'h00);
    chk("post_rst_masked", {7'd0, underrun}, 8'h00);
    do_fetch(ZX_DATA);
    for (int i = 0; i < 16; i++) begin
      strobe7();
      chk($sformatf("clean_pix%0d", i), {4'd0, colour}, {4'd0, zx_exp[63-4*i -: 4]});
    end
    strobe7();
    chk("clean_under_pulse", {7'd0, underrun}, 8'h01);
    chk("clean_under_colour", {4'd0, colour}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
